fb_write_arbiter: RTL

- Shares the single framebuffer write port (wea/addra/dina) of the HDMI pattern generator between two write requesters: requester 0 is the AXI-full slave write path, requester 1 is the hardware fill/clear engine.
- Uses round-robin arbitration with bounded bursts.
- Can optionally restrict writes to vertical blanking to avoid tearing.
- Runs in the clk_100 domain and synchronizes the pixel-domain v_valid.

---
 rtl/fb_write_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port between the AXI write
// path (requester 0) and the fill/clear engine (requester 1), with optional vblank gating.
module fb_write_arbiter #(
  parameter int MAX_BURST   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk_100,
  input  logic              resetn,
  input  logic              v_valid_in,
  input  logic              blank_only,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic [1:0]        gnt,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       stall_cnt
);

  // State codes double as the one-hot grant vector, so gnt is just the state register.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GRANT0 = 2'b01;
  localparam logic [1:0] ST_GRANT1 = 2'b10;

  localparam int                BEAT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  logic [1:0]             state, state_nxt;
  logic                   last, last_nxt;
  logic [BEAT_W-1:0]      beat_cnt, beat_nxt;
  logic [SYNC_STAGES-1:0] vv_sync;
  logic                   vv_s;
  logic                   vv_d;
  logic                   allowed;
  logic                   acc0;
  logic                   acc1;
  logic                   burst_done;

  assign vv_s       = vv_sync[SYNC_STAGES-1];
  assign allowed    = !blank_only || !vv_s;
  assign r0_ready   = resetn && allowed && (state == ST_GRANT0);
  assign r1_ready   = resetn && allowed && (state == ST_GRANT1);
  assign acc0       = r0_valid && r0_ready;
  assign acc1       = r1_valid && r1_ready;
  assign burst_done = (beat_cnt == LAST_BEAT);
  assign gnt        = state;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    beat_nxt  = beat_cnt;
    case (state)
      ST_IDLE: begin
        beat_nxt = '0;
        if (allowed) begin
          // Requester 0 wins a tie only when requester 1 held the previous grant.
          if (r0_valid && (!r1_valid || last)) begin
            state_nxt = ST_GRANT0;
          end else if (r1_valid) begin
            state_nxt = ST_GRANT1;
          end
        end
      end
      ST_GRANT0: begin
        if (acc0) begin
          beat_nxt = beat_cnt + BEAT_W'(1);
        end
        if ((acc0 && burst_done) || !r0_valid) begin
          state_nxt = ST_IDLE;
          last_nxt  = 1'b0;
          beat_nxt  = '0;
        end
      end
      ST_GRANT1: begin
        if (acc1) begin
          beat_nxt = beat_cnt + BEAT_W'(1);
        end
        if ((acc1 && burst_done) || !r1_valid) begin
          state_nxt = ST_IDLE;
          last_nxt  = 1'b1;
          beat_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_100) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // v_valid_in is asynchronous to clk_100; only vv_s and later stages are safe to use.
  always_ff @(posedge clk_100) begin
    if (!resetn) begin
      vv_sync <= '0;
      vv_d    <= 1'b0;
    end else begin
      vv_sync <= {vv_sync[SYNC_STAGES-2:0], v_valid_in};
      vv_d    <= vv_s;
    end
  end

  always_ff @(posedge clk_100) begin
    if (!resetn) begin
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      wea <= acc0 || acc1;
      if (acc1) begin
        addra <= r1_addr;
        dina  <= r1_data;
      end else if (acc0) begin
        addra <= r0_addr;
        dina  <= r0_data;
      end
    end
  end

  // Vblank entry is the falling edge of the synchronized vertical-active flag.
  always_ff @(posedge clk_100) begin
    if (!resetn) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (vv_d && !vv_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (!allowed && (r0_valid || r1_valid) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
